// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box and Rcon tables, key-schedule FSM encoding, sizes.
package aes_pkg;

  localparam int NR = 10;
  localparam int KW = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constants for rounds 1..10; any other index yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] k);
    logic [7:0] r;
    case (k)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational; shared by the key schedule and SubBytes.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  assign out_byte = sbox(in_byte);
endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: expands one cipher key into rk0..rk10, one round
// key per clock, and serves them through a registered indexed read port.
module aes_key_expansion
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [KW-1:0] key_in,
  input  logic          key_valid,
  output logic          key_ready,
  output logic          busy,
  output logic          done,
  input  logic [3:0]    rk_idx,
  output logic [KW-1:0] rk_out
);
  state_e        state_d, state_q;
  logic [3:0]    round_d, round_q;
  logic [KW-1:0] keys_d [0:NR];
  logic [KW-1:0] keys_q [0:NR];
  logic [KW-1:0] prev_d, prev_q;
  logic          key_ready_d, key_ready_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;
  logic [KW-1:0] rk_out_d, rk_out_q;
  logic [31:0]   rot_w, sub_w, t_w;
  logic [31:0]   n0, n1, n2, n3;
  logic [KW-1:0] next_rk;

  // prev_q mirrors the most recently written round key, so no storage read mux is needed.
  assign rot_w = {prev_q[23:0], prev_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (rot_w[8*i +: 8]),
      .out_byte (sub_w[8*i +: 8])
    );
  end

  assign t_w     = sub_w ^ {rcon(round_q), 24'h000000};
  assign n0      = prev_q[127:96] ^ t_w;
  assign n1      = prev_q[95:64]  ^ n0;
  assign n2      = prev_q[63:32]  ^ n1;
  assign n3      = prev_q[31:0]   ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  // Next-state, storage-write and registered-output logic.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    prev_d  = prev_q;
    keys_d  = keys_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (key_valid) begin
          state_d   = ST_EXPAND;
          round_d   = 4'd1;
          prev_d    = key_in;
          keys_d[0] = key_in;
        end else begin
          state_d = state_q;
        end
      end
      ST_EXPAND: begin
        prev_d          = next_rk;
        keys_d[round_q] = next_rk;
        if (round_q == 4'(NR)) begin
          state_d = ST_DONE;
          round_d = 4'd0;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        round_d = 4'd0;
      end
    endcase

    key_ready_d = (state_d != ST_EXPAND);
    busy_d      = (state_d == ST_EXPAND);
    done_d      = (state_d == ST_DONE);

    // Reads see storage before this edge's write: no write-through bypass.
    if (rk_idx <= 4'(NR)) begin
      rk_out_d = keys_q[rk_idx];
    end else begin
      rk_out_d = {KW{1'b0}};
    end
  end

  // State, storage and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      round_q     <= 4'd0;
      prev_q      <= {KW{1'b0}};
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rk_out_q    <= {KW{1'b0}};
      for (int i = 0; i <= NR; i++) begin
        keys_q[i] <= {KW{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      prev_q      <= prev_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rk_out_q    <= rk_out_d;
      for (int i = 0; i <= NR; i++) begin
        keys_q[i] <= keys_d[i];
      end
    end
  end

  assign key_ready = key_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rk_out    = rk_out_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Scoreboard bench for aes_key_expansion: word-level FIPS-197 reference model with an
// S-box derived from GF(2^8) inversion, stimulus pushes expectations, a monitor checks.
module tb_aes_key_expansion;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  aes_key_expansion dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done),
    .rk_idx    (rk_idx),
    .rk_out    (rk_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: kind 0 = rk_out, kind 1 = {key_ready,busy,done}
  bit           kind_q[$];
  logic [127:0] exp_q[$];
  int           due_q[$];
  string        nm_q[$];

  logic [127:0] store    [0:10];
  logic [127:0] model_rk [0:10];
  logic [7:0]   sbox_tab [0:255];
  logic [127:0] mon_act;

  always @(posedge clk) begin
    #1;
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      checks++;
      if (kind_q[0]) mon_act = {125'd0, key_ready, busy, done};
      else           mon_act = rk_out;
      if (due_q[0] != cyc) begin
        errors++;
        $display("FAIL %s: check missed its cycle (due %0d, now %0d)", nm_q[0], due_q[0], cyc);
      end else if (mon_act !== exp_q[0]) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", nm_q[0], mon_act, exp_q[0], cyc);
      end
      void'(kind_q.pop_front());
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
      void'(nm_q.pop_front());
    end
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] r;
    logic [7:0] s;
    for (int y = 1; y < 256; y++) begin
      if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    r = inv;
    s = inv;
    for (int i = 0; i < 4; i++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  task automatic compute_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_rk(input logic [127:0] v, input string nm);
    kind_q.push_back(1'b0); exp_q.push_back(v); due_q.push_back(cyc + 1); nm_q.push_back(nm);
  endtask

  task automatic push_status(input logic [2:0] s, input string nm);
    kind_q.push_back(1'b1); exp_q.push_back({125'd0, s}); due_q.push_back(cyc + 1); nm_q.push_back(nm);
  endtask

  task automatic clear_store();
    for (int i = 0; i < 11; i++) store[i] = 128'd0;
  endtask

  task automatic read_chk(input logic [3:0] idx, input logic [127:0] v, input string nm);
    rk_idx = idx;
    push_rk(v, nm);
    @(negedge clk);
  endtask

  task automatic do_accept(input logic [127:0] key);
    compute_model(key);
    key_in    = key;
    key_valid = 1'b1;
    rk_idx    = 4'd0;
    push_rk(store[0], "accept_old_rk0");
    push_status(3'b010, "accept_status");
    @(negedge clk);
    key_valid = 1'b0;
    store[0]  = key;
  endtask

  // Runs edges 1..10; a nonzero ign holds a foreign key on key_valid for edges 1..ign,
  // a nonzero stop_at asserts rst at that edge instead of continuing.
  task automatic run_expand(input int ign, input int stop_at);
    for (int k = 1; k <= 10; k++) begin
      rk_idx = 4'(k);
      if (k == stop_at) begin
        rst = 1'b1;
        push_rk(128'd0, "abort_rk_out");
        push_status(3'b100, "abort_status");
        @(negedge clk);
        rst = 1'b0;
        clear_store();
        return;
      end
      if (k <= ign) begin
        key_valid = 1'b1;
        key_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        key_valid = 1'b0;
      end
      push_rk(store[k], "write_edge_old");
      push_status((k == 10) ? 3'b101 : 3'b010, (k == 10) ? "done_edge" : "expand_status");
      @(negedge clk);
      store[k] = model_rk[k];
    end
    key_valid = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < 11; i++) read_chk(4'(i), store[i], "read_rk");
    read_chk(4'($urandom_range(11, 15)), 128'd0, "read_oob");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k1;
    logic [127:0] k2;
    k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    k2 = 128'h000102030405060708090a0b0c0d0e0f;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_ref(8'(i));
    clear_store();
    rst = 1'b1; key_valid = 1'b0; key_in = 128'd0; rk_idx = 4'd0;
    @(negedge clk);
    push_status(3'b100, "reset_status");
    push_rk(128'd0, "reset_rk_out");
    @(negedge clk);
    rst = 1'b0;

    // FIPS-197 key
    do_accept(k1);
    run_expand(0, 0);
    read_chk(4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "fips_rk1");
    read_chk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10");
    read_chk(4'd0,  k1, "fips_rk0");
    read_all();

    // Second key, then reload from DONE
    do_accept(k2);
    run_expand(0, 0);
    read_chk(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "k2_rk10");
    do_accept(k1);
    run_expand(0, 0);
    read_chk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "reload_rk10");

    // Foreign key presented during EXPAND is ignored
    do_accept({$urandom(), $urandom(), $urandom(), $urandom()});
    run_expand(5, 0);
    read_all();

    // Reset mid-expansion, then re-issue
    do_accept({$urandom(), $urandom(), $urandom(), $urandom()});
    run_expand(0, 5);
    read_all();
    do_accept({$urandom(), $urandom(), $urandom(), $urandom()});
    run_expand(0, 0);
    read_all();

    // Out-of-range indices and single-cycle read latency
    read_chk(4'd11, 128'd0, "idx11");
    read_chk(4'd15, 128'd0, "idx15");
    read_chk(4'd1,  store[1],  "lat_rk1");
    read_chk(4'd10, store[10], "lat_rk10");
    read_chk(4'd0,  store[0],  "lat_rk0");

    // rst and key_valid on the same edge
    rst = 1'b1; key_valid = 1'b1; key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    rk_idx = 4'd0;
    push_status(3'b100, "rst_vs_valid");
    @(negedge clk);
    rst = 1'b0; key_valid = 1'b0;
    clear_store();
    push_status(3'b100, "rst_vs_valid_idle");
    read_chk(4'd0, 128'd0, "rst_vs_valid_rk0");

    // Randomized keys
    for (int n = 0; n < 4; n++) begin
      do_accept({$urandom(), $urandom(), $urandom(), $urandom()});
      run_expand(0, 0);
      read_all();
    end

    for (int i = 0; i < 3; i++) @(negedge clk);
    if (due_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d checks still pending, expected 0", due_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
- Iterative AES-128 key schedule in the Encryption datapath.
- Takes one 128-bit cipher key and generates the 11 round keys (rk0..rk10), one per clock. It stores them internally.
- Serves them through an indexed, registered read port to the AddRoundKey stage, which feeds SubBytes.
- Byte ordering matches SubBytes: byte 0 is bits [127:120]; word w0 is bits [127:96].

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported.
- KW, 128, key and round-key width in bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- key_in  input  128  cipher key; sampled when key_valid && key_ready
- key_valid  input  1  key_in is valid
- key_ready  output  1  block can accept a new key (high in IDLE and DONE)
- busy  output  1  expansion in progress
- done  output  1  all 11 round keys valid; held until the next accepted key or reset
- rk_idx  input  4  round-key index to read, 0..10
- rk_out  output  128  round key rk_idx, registered (1-cycle read latency)

Behaviour:
- Reset: rst is synchronous and active-high. One clock: clk.
  - Reset forces state=IDLE, key_ready=1, busy=0, done=0, rk_out=0, round counter=0.
  - All 11 key-storage entries are cleared to 0.
  - Reset mid-expansion aborts immediately; no partial keys survive.
- States:
  - IDLE: key_ready=1. On accept, go to EXPAND.
  - EXPAND: key_ready=0, busy=1. Runs for exactly 10 cycles, with the round counter running 1..10. After the cycle that writes rk10, go to DONE.
  - DONE: done=1, key_ready=1. A new accept goes to EXPAND, clears done on the same edge, and overwrites storage.
- Timing:
  - Accept edge (cycle 0): rk0 = key_in is written; the round counter is set to 1.
  - Edge k, k=1..10: rk[k] is written from rk[k-1].
  - done rises on edge 10 after accept, so total latency from accept to done is 10 clocks.
  - key_valid is ignored while in EXPAND (key_ready=0). No queuing.
- Round function, given prev = {w0,w1,w2,w3}:
  - t = SubWord(RotWord(w3)) XOR {Rcon[k],24'h0}.
  - RotWord is a left rotate by 8 bits.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - rk[k] = {n0,n1,n2,n3}.
  - SubWord uses 4 S-box instances, combinational within one cycle.
- Read port:
  - rk_out <= storage[rk_idx] every cycle.
  - rk_idx > 10 gives rk_out <= 0.
  - Reads are allowed in any state. Reading index k is valid once rk[k] is written, which allows overlap with the cipher round pipeline.
  - Reading the same index on the edge it is written returns the old value (no bypass).
- Simultaneous rst and key_valid: rst wins; the key is not accepted.

Decomposition:
- Shared package aes_pkg holds:
  - the S-box table function or constant;
  - the Rcon table (10 x 8 bits);
  - the state encoding (IDLE=2'd0, EXPAND=2'd1, DONE=2'd2);
  - NR and KW constants.
- One natural sub-module: aes_sbox (8-bit in, 8-bit out, combinational), shared with SubBytes. Instantiated 4 times for SubWord.
- FSM, counter, storage and read port live in the top module.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, one-cycle valid.
   - done exactly 10 clocks after accept.
   - rk_idx=1 gives a0fafe1788542cb123a339392a6c7605.
   - rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
   - rk_idx=0 returns the key.
2. Key 000102030405060708090a0b0c0d0e0f.
   - rk10 = 13111d7fe3944a17f307a78b4d2b30c5.
   - Then load the key from scenario 1 while in DONE: done drops on the accept edge, and rk10 updates to the scenario-1 value.
3. Assert key_valid with a different key during EXPAND.
   - key_ready=0 and the key is ignored.
   - Final rk10 equals the original key's value.
4. Assert rst at cycle 5 of EXPAND.
   - Next edge: done=0, busy=0, key_ready=1.
   - All indices read 0.
   - A re-issued key expands correctly.
5. rk_idx=11 and rk_idx=15 give rk_out=0. Read latency is exactly 1 cycle: change rk_idx and check that rk_out updates on the next edge.
6. rst and key_valid high on the same edge: key not accepted, state IDLE, busy=0.
